// File: rtl/reg_bank_bypass_pkg.sv
// rtl/reg_bank_bypass_pkg.sv - shared types and helpers for the bypassing register bank
// Purpose: state encoding for the clear sequencer and the address range helper.
// Ports: none (package reg_bank_pkg).
package reg_bank_pkg;

   localparam int STATE_W = 1;

   typedef enum logic [STATE_W-1:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // True when addr names an implemented register (bank may be smaller than 2**REG_BITS).
   function automatic logic in_range(input logic [31:0] addr, input logic [31:0] size);
      return addr < size;
   endfunction

endpackage

// File: rtl/reg_bank_bypass_if.sv
// rtl/reg_bank_bypass_if.sv - write/read bus bundle for the register bank
// Purpose: groups the write port, the dual read port and the ready flag.
// Ports: write_enable/write_address/write_data, read_enable/address_a/address_b
//        (master -> slave); data_a/data_b/ready (slave -> master).
interface reg_bank_bypass_if #(
   parameter int BITS     = 8,
   parameter int REG_BITS = 3
);
   logic                write_enable;
   logic [REG_BITS-1:0] write_address;
   logic [BITS-1:0]     write_data;
   logic                read_enable;
   logic [REG_BITS-1:0] address_a;
   logic [REG_BITS-1:0] address_b;
   logic [BITS-1:0]     data_a;
   logic [BITS-1:0]     data_b;
   logic                ready;

   modport master (
      output write_enable, write_address, write_data,
      output read_enable, address_a, address_b,
      input  data_a, data_b, ready
   );

   modport slave (
      input  write_enable, write_address, write_data,
      input  read_enable, address_a, address_b,
      output data_a, data_b, ready
   );
endinterface

// File: rtl/reg_bank_clear_seq.sv
// rtl/reg_bank_clear_seq.sv - post-reset clear walker for the register bank
// Purpose: after reset, writes zero to every register once, then stays in RUN.
// Ports: clk, rst_n (async active-low); clear_we/clear_addr drive the storage
//        write port while clearing; done is high from the edge that enters RUN.
module reg_bank_clear_seq
   import reg_bank_pkg::*;
#(
   parameter int REG_BITS = 3,
   parameter int REG_SIZE = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                clear_we,
   output logic [REG_BITS-1:0] clear_addr,
   output logic                done
);

   localparam logic [STATE_W-1:0]  S_CLEAR = CLEAR;
   localparam logic [STATE_W-1:0]  S_RUN   = RUN;
   localparam logic [REG_BITS-1:0] LAST    = REG_BITS'(REG_SIZE - 1);

   logic [STATE_W-1:0]  state;
   logic [REG_BITS-1:0] ptr;

   // One register cleared per edge; the edge that clears the last entry enters RUN,
   // so done rises exactly REG_SIZE edges after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_CLEAR;
         ptr   <= '0;
      end else if (state == S_CLEAR) begin
         if (ptr == LAST) begin
            state <= S_RUN;
         end else begin
            ptr <= ptr + REG_BITS'(1);
         end
      end
   end

   assign clear_we   = (state == S_CLEAR);
   assign clear_addr = ptr;
   assign done       = (state == S_RUN);

endmodule

// File: rtl/reg_bank_bypass.sv
// rtl/reg_bank_bypass.sv - single-write dual-read register bank with write-first bypass
// Purpose: architectural register storage with post-reset clear, registered reads
//          gated by read_enable, same-cycle write-to-read bypass and range protection.
// Ports: clk, rst_n (async active-low), bus (reg_bank_bypass_if.slave).
// Optional: REG_BANK_ZERO_REG_EN makes register 0 a hardwired zero.
module reg_bank_bypass
   import reg_bank_pkg::*;
#(
   parameter int BITS     = 8,
   parameter int REG_BITS = 3,
   parameter int REG_SIZE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   reg_bank_bypass_if.slave bus
);

   logic [BITS-1:0]     mem [REG_SIZE];
   logic                clear_we;
   logic [REG_BITS-1:0] clear_addr;
   logic                done;
   logic                wr_zero, a_zero, b_zero;
   logic                ext_we;
   logic                mem_we;
   logic [REG_BITS-1:0] mem_addr;
   logic [BITS-1:0]     mem_wdata;
   logic [BITS-1:0]     rd_a, rd_b;

   reg_bank_clear_seq #(
      .REG_BITS (REG_BITS),
      .REG_SIZE (REG_SIZE)
   ) u_clear_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_we   (clear_we),
      .clear_addr (clear_addr),
      .done       (done)
   );

`ifdef REG_BANK_ZERO_REG_EN
   assign wr_zero = (bus.write_address == '0);
   assign a_zero  = (bus.address_a == '0);
   assign b_zero  = (bus.address_b == '0);
`else
   assign wr_zero = 1'b0;
   assign a_zero  = 1'b0;
   assign b_zero  = 1'b0;
`endif

   // An external write that will actually land; also the bypass qualifier.
   assign ext_we = bus.write_enable && !wr_zero
                   && in_range(32'(bus.write_address), 32'(REG_SIZE));

   assign mem_we    = done ? ext_we            : clear_we;
   assign mem_addr  = done ? bus.write_address : clear_addr;
   assign mem_wdata = done ? bus.write_data    : '0;

   // Storage has no reset; the clear sequencer initialises it before reads open up.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   always_comb begin
      rd_a = '0;
      if (in_range(32'(bus.address_a), 32'(REG_SIZE)) && !a_zero) begin
         rd_a = (ext_we && (bus.address_a == bus.write_address)) ? bus.write_data
                                                                 : mem[bus.address_a];
      end
   end

   always_comb begin
      rd_b = '0;
      if (in_range(32'(bus.address_b), 32'(REG_SIZE)) && !b_zero) begin
         rd_b = (ext_we && (bus.address_b == bus.write_address)) ? bus.write_data
                                                                 : mem[bus.address_b];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.data_a <= '0;
         bus.data_b <= '0;
      end else if (!done) begin
         bus.data_a <= '0;
         bus.data_b <= '0;
      end else if (bus.read_enable) begin
         bus.data_a <= rd_a;
         bus.data_b <= rd_b;
      end
   end

   assign bus.ready = done;

endmodule

// File: doc/reg_bank_bypass.md
Name: reg_bank_bypass

Overview:
- Parametrised successor to the team's single-write, dual-read register bank.
- Adds:
  - asynchronous active-low reset;
  - a post-reset clear sequencer, so no X values reach the datapath;
  - concurrent read and write in the same cycle, with write-first bypass;
  - explicit read enable;
  - out-of-range address protection.
- Sits between the decode and execute stages of the REDUX-V datapath as the architectural register storage.

Parameters:
- BITS, 8, data width of each register.
- REG_BITS, 3, address width.
- REG_SIZE, 8, number of registers; must satisfy REG_SIZE <= 2**REG_BITS and REG_SIZE >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- write_enable  input  1  write strobe, sampled at posedge clk.
- write_address  input  REG_BITS  write target.
- write_data  input  BITS  write value.
- read_enable  input  1  updates data_a/data_b at the next posedge when high.
- address_a  input  REG_BITS  read port A address.
- address_b  input  REG_BITS  read port B address.
- data_a  output  BITS  registered read data, port A.
- data_b  output  BITS  registered read data, port B.
- ready  output  1  high once the clear sequence has completed.

Behaviour:
- Reset (rst_n low, asynchronous):
  - data_a = 0, data_b = 0, ready = 0.
  - FSM enters CLEAR; clear pointer = 0.
  - The storage array itself has no async reset.
- FSM state CLEAR:
  - Each posedge writes 0 to reg[ptr] and increments ptr.
  - After the write to index REG_SIZE-1, the next state is RUN.
  - ready rises on the edge that enters RUN, exactly REG_SIZE cycles after rst_n deasserts.
  - In CLEAR, write_enable and read_enable are ignored; data_a/data_b hold 0.
- FSM state RUN:
  - Remains in RUN until the next reset. ready = 1.
  - Write: if write_enable=1 and write_address < REG_SIZE, then reg[write_address] <= write_data.
  - Write to an address >= REG_SIZE is discarded silently.
  - Read: if read_enable=1, then data_x <= reg[address_x] at the posedge. Read latency is 1 cycle.
  - read_enable=0: data_a/data_b hold their previous values. This holds even if a write targets the held address.
  - Read address >= REG_SIZE returns 0.
- Bypass:
  - Condition: read_enable=1, write_enable=1, address_x == write_address, address in range.
  - Result: data_x <= write_data in the same edge (write-first).
  - Both ports bypass independently. address_a == address_b is legal; both ports return the same value.
- Reset asserted mid-operation:
  - Outputs zero immediately.
  - Any in-flight write is lost.
  - The full clear sequence reruns.

Optional Feature:
- Macro: REG_BANK_ZERO_REG_EN.
- When defined:
  - Register 0 is hardwired zero; reads of address 0 always return 0.
  - Writes to address 0 are discarded.
  - Bypass never applies to address 0.
  - CLEAR still walks all REG_SIZE entries, so the ready timing is unchanged.
- When undefined: register 0 is an ordinary register.

Decomposition:
- Package reg_bank_pkg contains:
  - enum state_t {CLEAR, RUN};
  - localparam for the state encoding width;
  - a helper function in_range(addr, size).
- Sub-module reg_bank_clear_seq:
  - REG_BITS-wide pointer counter plus CLEAR/RUN FSM.
  - Outputs: clear_we, clear_addr, done.
  - The top level muxes between clear_we/clear_addr and the external write port, based on done.

Test Plan:
- Clear timing: rst_n low 3 cycles, then release.
  - ready stays low for exactly 8 cycles, rises on the 8th edge.
  - After that, reads of addresses 0..7 all return 0x00.
- Basic write/read: write 0xA5 to reg 3; next cycle read_enable=1 with address_a=3, address_b=2.
  - One edge later: data_a=0xA5, data_b=0x00.
- Bypass: in one cycle write 0x3C to reg 5, with read_enable=1 and address_a=address_b=5.
  - Same edge: data_a=data_b=0x3C.
  - Prior contents of reg 5 never appear.
- Hold and ignore rules:
  - read_enable=0 while writing 0x77 to the address last read: data_a is unchanged.
  - A write issued during CLEAR does not land: reading that register after ready returns 0x00.
- Mid-operation reset:
  - Populate regs 1..7 with nonzero values, pulse rst_n low in the middle of a write.
  - data outputs go to 0 immediately, ready drops, the clear reruns (8 cycles), then all regs read 0x00.
- Zero register (run with REG_BANK_ZERO_REG_EN defined):
  - Write 0xFF to reg 0 while simultaneously reading reg 0: data_a=0x00 on that edge and on a later read.
